// File: rtl/dmem_arbiter.sv
// Two-port round-robin front end for a 32-bit, big-endian, word-write-only data memory.
// Checks requests, runs sub-word stores as read-modify-write, and aligns and extends sub-word loads.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic        p0_signed,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic        p1_signed,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rbuf_q, rbuf_d;

  logic        any_req;
  logic        sel_port;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic        sel_signed;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_illegal;
  logic        word_store;
  logic [31:0] merged_word;
  logic [31:0] load_data;
  logic [31:0] resp_rdata;

  // Tie goes to the port that did not win last time; a lone requester always wins.
  assign any_req    = p0_req | p1_req;
  assign sel_port   = (p0_req && p1_req) ? ~last_grant_q : p1_req;
  assign sel_we     = sel_port ? p1_we     : p0_we;
  assign sel_size   = sel_port ? p1_size   : p0_size;
  assign sel_signed = sel_port ? p1_signed : p0_signed;
  assign sel_addr   = sel_port ? p1_addr   : p0_addr;
  assign sel_wdata  = sel_port ? p1_wdata  : p0_wdata;

  assign sel_illegal = (sel_size == 2'b11)
                    || (sel_size == SZ_HALF && sel_addr[0])
                    || (sel_size == SZ_WORD && sel_addr[1:0] != 2'b00)
                    || (sel_addr >= 32'(MEM_BYTES));

  assign word_store = we_q && (size_q == SZ_WORD);

  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] data,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [31:0] res;
    res = word;
    if (size == SZ_BYTE) begin
      case (off)
        2'd0:    res[31:24] = data[7:0];
        2'd1:    res[23:16] = data[7:0];
        2'd2:    res[15:8]  = data[7:0];
        default: res[7:0]   = data[7:0];
      endcase
    end else if (off[1]) begin
      res[15:0] = data[15:0];
    end else begin
      res[31:16] = data[15:0];
    end
    return res;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: res = {{24{sgn & b[7]}}, b};
      SZ_HALF: res = {{16{sgn & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign merged_word = lane_merge(rbuf_q, wdata_q, size_q, addr_q[1:0]);
  assign load_data   = lane_extract(rbuf_q, size_q, addr_q[1:0], signed_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      rbuf_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      rbuf_q       <= rbuf_d;
    end
  end

  // NOTE: every signal gets a hold default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    size_d       = size_q;
    signed_d     = signed_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    rbuf_d       = rbuf_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d      = sel_port;
          last_grant_d = sel_port;
          we_d         = sel_we;
          size_d       = sel_size;
          signed_d     = sel_signed;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          err_d        = sel_illegal;
          state_d      = sel_illegal ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!word_store) rbuf_d = mem_rdata;
        state_d = (we_q && !word_store) ? WRITE : RESP;
      end
      WRITE: state_d = RESP;
      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state and latched fields.
  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    p0_ack     = 1'b0;
    p1_ack     = 1'b0;
    p0_err     = 1'b0;
    p1_err     = 1'b0;
    p0_rdata   = '0;
    p1_rdata   = '0;
    resp_rdata = (err_q || we_q) ? 32'h0 : load_data;
    case (state_q)
      ACCESS: begin
        mem_addr = {addr_q[31:2], 2'b00};
        if (word_store) begin
          mem_write = 1'b1;
          mem_wdata = wdata_q;
        end else begin
          mem_read = 1'b1;
        end
      end
      WRITE: begin
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_write = 1'b1;
        mem_wdata = merged_word;
      end
      RESP: begin
        if (grant_q) begin
          p1_ack   = 1'b1;
          p1_err   = err_q;
          p1_rdata = resp_rdata;
        end else begin
          p0_ack   = 1'b1;
          p0_err   = err_q;
          p0_rdata = resp_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed transactions push expected responses,
// a negedge monitor pops and compares on every ack, with a byte-array memory model behind the port.
module tb_dmem_arbiter;

  localparam int MEM_BYTES = 256;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req [2];
  logic        we [2];
  logic [1:0]  size [2];
  logic        sgn [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        ack [2];
  logic        err [2];
  logic [31:0] rdata [2];
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(req[0]), .p0_we(we[0]), .p0_size(size[0]), .p0_signed(sgn[0]),
    .p0_addr(addr[0]), .p0_wdata(wdata[0]),
    .p0_ack(ack[0]), .p0_err(err[0]), .p0_rdata(rdata[0]),
    .p1_req(req[1]), .p1_we(we[1]), .p1_size(size[1]), .p1_signed(sgn[1]),
    .p1_addr(addr[1]), .p1_wdata(wdata[1]),
    .p1_ack(ack[1]), .p1_err(err[1]), .p1_rdata(rdata[1]),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Big-endian byte memory: combinational read, word write on the clock edge.
  logic [7:0] mem [MEM_BYTES];
  logic [7:0] widx;
  assign widx = {mem_addr[7:2], 2'b00};
  assign mem_rdata = {mem[widx], mem[widx + 8'd1], mem[widx + 8'd2], mem[widx + 8'd3]};
  always @(posedge clk) begin
    if (mem_write) begin
      mem[widx]        <= mem_wdata[31:24];
      mem[widx + 8'd1] <= mem_wdata[23:16];
      mem[widx + 8'd2] <= mem_wdata[15:8];
      mem[widx + 8'd3] <= mem_wdata[7:0];
    end
  end

  typedef struct {logic err; logic [31:0] rdata;} exp_t;
  typedef struct {int port; int cyc;} ack_t;
  exp_t sb0[$];
  exp_t sb1[$];
  ack_t ack_log[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [31:0] last_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic compare_ack(input int p);
    exp_t e;
    ack_log.push_back('{port: p, cyc: cyc});
    if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
      check($sformatf("unexpected_ack_p%0d", p), 32'd1, 32'd0);
    end else begin
      e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
      check($sformatf("err_p%0d", p), {31'b0, err[p]}, {31'b0, e.err});
      check($sformatf("rdata_p%0d", p), rdata[p], e.rdata);
    end
  endtask

  // Monitor: independent of stimulus, compares every ack against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      check("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
      check("dual_ack", {31'b0, ack[0] & ack[1]}, 32'd0);
      if (mem_read) rd_cnt++;
      if (mem_write) begin
        wr_cnt++;
        last_wdata = mem_wdata;
      end
      for (int p = 0; p < 2; p++) begin
        if (ack[p]) compare_ack(p);
        else check($sformatf("idle_out_p%0d", p), rdata[p] | {31'b0, err[p]}, 32'd0);
      end
    end
  end

  task automatic drive(input int p, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req[p] = 1'b1; we[p] = w; size[p] = sz; sgn[p] = sg; addr[p] = a; wdata[p] = wd;
  endtask

  task automatic idle(input int p);
    req[p] = 1'b0; we[p] = 1'b0; size[p] = 2'b00; sgn[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
  endtask

  task automatic push(input int p, input logic e, input logic [31:0] rd);
    if (p == 0) sb0.push_back('{err: e, rdata: rd});
    else        sb1.push_back('{err: e, rdata: rd});
  endtask

  task automatic wait_ack(input int p, input string nm, output int ca);
    int n;
    ca = -1;
    n = 0;
    while (ca < 0 && n < 20) begin
      @(negedge clk);
      if (ack[p]) ca = cyc;
      n++;
    end
    if (ca < 0) check({nm, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic txn(input int p, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd, input logic e,
                     input logic [31:0] rd, input int lat, input string nm);
    int c0, ca;
    @(posedge clk); #1;
    push(p, e, rd);
    drive(p, w, sz, sg, a, wd);
    c0 = cyc;
    wait_ack(p, nm, ca);
    if (ca >= 0) check({nm, "_latency"}, 32'(ca - c0 + 1), 32'(lat));
    @(posedge clk); #1;
    idle(p);
  endtask

  task automatic chk_quiet(input string nm);
    check({nm, "_ctrl"}, {26'b0, ack[0], ack[1], err[0], err[1], mem_read, mem_write}, 32'd0);
    check({nm, "_data"}, rdata[0] | rdata[1] | mem_addr | mem_wdata, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 chk_quiet("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int r0, w0, c0, ca;
    logic [31:0] snap;
    idle(0);
    idle(1);
    #1 chk_quiet("reset_init");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Word store then word load.
    w0 = wr_cnt;
    txn(0, 1, SZ_W, 0, 32'h14, 32'hDEADBEEF, 0, 32'h0, 3, "t1_sw");
    check("t1_sw_writes", 32'(wr_cnt - w0), 32'd1);
    check("t1_mem", {mem[8'h14], mem[8'h15], mem[8'h16], mem[8'h17]}, 32'hDEADBEEF);
    txn(0, 0, SZ_W, 0, 32'h14, 32'h0, 0, 32'hDEADBEEF, 3, "t1_lw");
    txn(1, 1, SZ_W, 0, 32'h20, 32'h11223344, 0, 32'h0, 3, "t1_sw_p1");

    // Byte store read-modify-write, then byte loads.
    r0 = rd_cnt;
    w0 = wr_cnt;
    txn(1, 1, SZ_B, 0, 32'h15, 32'h000000AA, 0, 32'h0, 4, "t2_sb");
    check("t2_sb_reads", 32'(rd_cnt - r0), 32'd1);
    check("t2_sb_writes", 32'(wr_cnt - w0), 32'd1);
    check("t2_sb_wdata", last_wdata, 32'hDEAABEEF);
    txn(1, 0, SZ_B, 0, 32'h15, 32'h0, 0, 32'h000000AA, 3, "t2_lbu");
    txn(1, 0, SZ_B, 1, 32'h15, 32'h0, 0, 32'hFFFFFFAA, 3, "t2_lb");

    // Half store, then half and byte loads.
    txn(0, 1, SZ_H, 0, 32'h16, 32'h00001234, 0, 32'h0, 4, "t3_sh");
    check("t3_wdata", last_wdata, 32'hDEAA1234);
    txn(0, 0, SZ_H, 1, 32'h14, 32'h0, 0, 32'hFFFFDEAA, 3, "t3_lh");
    txn(0, 0, SZ_H, 1, 32'h16, 32'h0, 0, 32'h00001234, 3, "t3_lh_hi");
    txn(1, 0, SZ_B, 1, 32'h17, 32'h0, 0, 32'h00000034, 3, "t3_lb_pos");

    // Illegal requests: ack with err on the 2nd cycle, memory untouched.
    r0 = rd_cnt;
    w0 = wr_cnt;
    txn(0, 0, SZ_W, 0, 32'h16, 32'h0, 1, 32'h0, 2, "t5_misw");
    txn(1, 0, SZ_H, 0, 32'h13, 32'h0, 1, 32'h0, 2, "t5_mish");
    txn(0, 1, SZ_X, 0, 32'h14, 32'h55, 1, 32'h0, 2, "t5_size");
    txn(1, 0, SZ_B, 0, 32'h100, 32'h0, 1, 32'h0, 2, "t5_range");
    check("t5_no_mem_access", 32'(rd_cnt - r0 + wr_cnt - w0), 32'd0);

    // Continuous contention after reset: p0, p1, p0, p1 in 12 cycles.
    do_reset();
    @(posedge clk); #1;
    ack_log.delete();
    push(0, 0, 32'hDEAA1234); push(1, 0, 32'h11223344);
    push(0, 0, 32'hDEAA1234); push(1, 0, 32'h11223344);
    drive(0, 0, SZ_W, 0, 32'h14, 32'h0);
    drive(1, 0, SZ_W, 0, 32'h20, 32'h0);
    c0 = cyc;
    repeat (12) @(posedge clk);
    #1;
    idle(0);
    idle(1);
    check("t4_ack_count", 32'(ack_log.size()), 32'd4);
    if (ack_log.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("t4_grant%0d_port", k), 32'(ack_log[k].port), 32'(k % 2));
        check($sformatf("t4_grant%0d_cycle", k), 32'(ack_log[k].cyc - c0 + 1), 32'(3 * k + 3));
      end
    end

    // Reset while a byte store sits in ACCESS: discarded, memory unchanged.
    @(posedge clk); #1;
    snap = {mem[8'h14], mem[8'h15], mem[8'h16], mem[8'h17]};
    check("t6_mem_before", snap, 32'hDEAA1234);
    drive(0, 1, SZ_B, 0, 32'h14, 32'h000000FF);
    @(posedge clk); #1;
    check("t6_in_access", {31'b0, mem_read}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_quiet("t6_reset");
    idle(0);
    repeat (2) @(posedge clk);
    #1 chk_quiet("t6_held");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_mem_after", {mem[8'h14], mem[8'h15], mem[8'h16], mem[8'h17]}, 32'hDEAA1234);
    push(0, 0, 32'hDEAA1234);
    push(1, 0, 32'h11223344);
    drive(0, 0, SZ_W, 0, 32'h14, 32'h0);
    drive(1, 0, SZ_W, 0, 32'h20, 32'h0);
    c0 = cyc;
    wait_ack(0, "t6_p0", ca);
    if (ca >= 0) check("t6_p0_latency", 32'(ca - c0 + 1), 32'd3);
    @(posedge clk); #1;
    idle(0);
    wait_ack(1, "t6_p1", ca);
    if (ca >= 0) check("t6_p1_latency", 32'(ca - c0 + 1), 32'd6);
    @(posedge clk); #1;
    idle(1);
    repeat (3) @(posedge clk);

    check("sb0_drained", 32'(sb0.size()), 32'd0);
    check("sb1_drained", 32'(sb1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Controller in front of the byte-addressed, big-endian data memory (256 bytes, 32-bit word port, level-sensitive MemRead/MemWrite).
- Shares the memory between two requesters: port 0 (CPU load/store stage) and port 1 (DMA/debug loader).
- Arbitrates round-robin and checks alignment and range.
- Sequences byte/halfword stores as read-modify-write, because the memory only writes whole words.
- Extracts and extends sub-word load data.

Parameters:
MEM_BYTES, 256, memory size in bytes; legal addresses are 0 .. MEM_BYTES-1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
p0_req / p1_req  in  1  request; held high with fields stable until ack
p0_we / p1_we  in  1  1 = store, 0 = load
p0_size / p1_size  in  2  00 byte, 01 half, 10 word, 11 illegal
p0_signed / p1_signed  in  1  sign-extend sub-word loads
p0_addr / p1_addr  in  32  byte address
p0_wdata / p1_wdata  in  32  store data, right-justified for sub-word
p0_ack / p1_ack  out  1  one-cycle completion pulse
p0_err / p1_err  out  1  valid with ack; misaligned, out of range, or illegal size
p0_rdata / p1_rdata  out  32  load result, valid with ack, else 0
mem_addr  out  32  word-aligned address to memory ({addr[31:2],2'b00})
mem_wdata  out  32  word to write
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_rdata  in  32  memory read data, combinational from mem_addr

Behaviour:
- Reset (async, rst_n=0): state IDLE, last_grant=1, all outputs 0; takes effect immediately, no ack issued.
- Reset mid-operation: the transaction is discarded. Memory is modified only if reset follows a completed WRITE cycle.
- FSM states: IDLE, ACCESS, WRITE, RESP. All mem_* outputs decode from registered state and latched fields only; they are glitch-free.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port != last_grant. Update last_grant.
  - Latch we/size/signed/addr/wdata of the winner.
  - If the request is illegal, set err_q and go to RESP. Otherwise go to ACCESS.
  - Illegal means any of: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr >= MEM_BYTES.
- ACCESS: drive mem_addr.
  - Word store: mem_write=1, mem_wdata=wdata; go to RESP.
  - Any load or sub-word store: mem_read=1, capture mem_rdata into rbuf at the clock edge.
  - Next state is RESP for a load, WRITE for a sub-word store.
- WRITE: mem_write=1, mem_wdata = rbuf with the addressed lane replaced; go to RESP.
  - Byte lane at offset o: bits [31-8o -: 8].
  - Half at offset 0: bits [31:16]; offset 2: bits [15:0].
- RESP: pulse ack of the granted port for one cycle, with err and rdata.
  - Load data: addressed lane from rbuf, right-justified, zero-extended, or sign-extended if signed=1.
  - Word load: rbuf. Stores and err: rdata=0.
  - Next state: IDLE.
- mem_read and mem_write are never high together. Both are 0 in IDLE and RESP.
- Latency from the edge that samples req in IDLE to the ack cycle:
  - word load / word store: ack in 3rd cycle (IDLE, ACCESS, RESP);
  - sub-word store: 4th cycle;
  - error: 2nd cycle.
- Back-to-back throughput: one transaction per 3–4 cycles. A new grant is possible in the IDLE cycle after RESP.
- The non-granted port waits with req held; no ack is issued to it.
- The requester drops req in the cycle after ack. If req is still high in the following IDLE, it is treated as a new request.
- Deasserting req before ack is a protocol violation; the in-flight transaction still completes and acks.
- Only the granted port's ack/err/rdata may be nonzero.

Test Plan:
1. p0 word store 0xDEADBEEF @0x14, then word load @0x14 -> each acks 3 cycles after req sampled; mem_write exactly one cycle; rdata=0xDEADBEEF; memory bytes 0x14..0x17 = DE AD BE EF.
2. p1 byte store 0xAA @0x15 over test 1 -> one mem_read cycle then one mem_write with mem_wdata=0xDEAABEEF; byte load unsigned @0x15 -> 0x000000AA; signed -> 0xFFFFFFAA.
3. Half store 0x1234 @0x16, then signed half load @0x14 -> 0xFFFFDEAA.
4. After reset, both ports request simultaneously and continuously -> grants p0, p1, p0, p1; no overlapping acks; 4 word loads complete in 12 cycles.
5. Misaligned word load @0x16, half @0x13, size=11, addr 0x100 -> err=1 with ack on the 2nd cycle; mem_read/mem_write never asserted; rdata=0.
6. rst_n low during WRITE-pending sequence (in ACCESS of a byte store @0x14) -> all outputs 0 immediately, no ack, memory word unchanged; first request after release is serviced normally, p0 winning a tie.
